load_store_unit: RTL and testbench

- Sits between the execute stage and main_memory. Accepts one load or store request at a time over a valid/ready handshake and drives main_memory's address, write-code and write-data inputs, then returns formatted load data.
- main_memory only writes whole words and zero-fills sub-word writes. This block therefore performs read-modify-write for byte and halfword stores, so neighbouring bytes are preserved.
- It also sign- or zero-extends load data and rejects misaligned or out-of-range accesses without touching memory.

---
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between execute and main_memory: handshakes one request at a time,
// read-modify-writes sub-word stores and sign/zero-extends load data.
module load_store_unit #(
    parameter int MEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LD_ADDR,
        LD_DATA,
        ST_RD,
        ST_MERGE,
        ST_WR,
        ST_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic [1:0]  byteOff_q;
    logic [15:0] wdata_q;

    logic        readyD, validD, errD;
    logic [31:0] rdataD, memAddrD, memWdataD;
    logic [3:0]  memWriteD;

    logic        accept, reqErr, illegalF3, misaligned, outOfRange;
    logic [31:0] loadFmt, merged;
    logic [7:0]  selByte;
    logic [15:0] selHalf;

    assign accept = req_valid && req_ready;

    // Rejected requests never reach memory, so they are classified straight from the inputs.
    always_comb begin
        illegalF3  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                     || (req_is_store && req_funct3[2]);
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                     || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        outOfRange = req_addr >= 32'(MEM_BYTES);
        reqErr     = illegalF3 || misaligned || outOfRange;
    end

    always_comb begin
        selByte = mem_rdata[{byteOff_q, 3'b000} +: 8];
        selHalf = byteOff_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  loadFmt = {{24{selByte[7]}}, selByte};
            3'b001:  loadFmt = {{16{selHalf[15]}}, selHalf};
            3'b100:  loadFmt = {24'd0, selByte};
            3'b101:  loadFmt = {16'd0, selHalf};
            default: loadFmt = mem_rdata;
        endcase
    end

    // Only the addressed lane(s) of the old word are replaced; neighbours are preserved.
    always_comb begin
        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{byteOff_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{byteOff_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            funct3_q   <= 3'b000;
            byteOff_q  <= 2'b00;
            wdata_q    <= 16'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_addr   <= 32'd0;
            mem_write  <= 4'd0;
            mem_wdata  <= 32'd0;
        end else begin
            state_q    <= state_d;
            req_ready  <= readyD;
            resp_valid <= validD;
            resp_err   <= errD;
            resp_rdata <= rdataD;
            mem_addr   <= memAddrD;
            mem_write  <= memWriteD;
            mem_wdata  <= memWdataD;
            if ((state_q == IDLE) && accept) begin
                funct3_q  <= req_funct3;
                byteOff_q <= req_addr[1:0];
                wdata_q   <= req_wdata[15:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !reqErr) begin
                    if (!req_is_store)                   state_d = LD_ADDR;
                    else if (req_funct3[1:0] == 2'b10)   state_d = ST_WR;
                    else                                 state_d = ST_RD;
                end
            end
            LD_ADDR:  state_d = LD_DATA;
            LD_DATA:  state_d = IDLE;
            ST_RD:    state_d = ST_MERGE;
            ST_MERGE: state_d = ST_WR;
            ST_WR:    state_d = ST_DRAIN;
            ST_DRAIN: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output values for the next cycle; the register block above makes every output registered.
    always_comb begin
        readyD    = (state_d == IDLE);
        validD    = 1'b0;
        errD      = 1'b0;
        rdataD    = 32'd0;
        memAddrD  = mem_addr;
        memWriteD = 4'd0;
        memWdataD = 32'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reqErr) begin
                        validD = 1'b1;
                        errD   = 1'b1;
                    end else begin
                        memAddrD = {req_addr[31:2], 2'b00};
                        if (req_is_store && (req_funct3[1:0] == 2'b10)) begin
                            memWriteD = 4'd1;
                            memWdataD = req_wdata;
                        end
                    end
                end
            end
            LD_DATA: begin
                validD = 1'b1;
                rdataD = loadFmt;
            end
            ST_MERGE: begin
                memWriteD = 4'd1;
                memWdataD = merged;
            end
            ST_DRAIN: validD = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit with a byte-array reference model
// and a word-wide main_memory model with registered reads and delayed write commit.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(512)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // main_memory: address sampled at an edge, data after it; writes commit one edge after capture.
    logic [31:0] memWords[128];
    logic        wrPend = 1'b0;
    logic [6:0]  wrIdx;
    logic [31:0] wrData;

    always @(posedge clk) begin
        mem_rdata <= memWords[mem_addr[8:2]];
        if (wrPend) memWords[wrIdx] <= wrData;
        wrPend <= (mem_write != 4'd0);
        wrIdx  <= mem_addr[8:2];
        wrData <= mem_wdata;
    end

    int cycleCount = 0;
    always @(posedge clk) cycleCount++;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          acceptCycle;
        int          latency;
        int          writes;
        logic [31:0] wAddr;
        logic [31:0] wData;
    } exp_t;

    exp_t expQ[$];
    logic [7:0] refMem[512];
    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic bit refIsError(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int size;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    return 1'b1;
        endcase
        if (st && f3 > 3'd2) return 1'b1;
        if ((a % size) != 0) return 1'b1;
        return a >= 32'd512;
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] f3, input int a);
        logic [7:0]  b;
        logic [15:0] h;
        b = refMem[a];
        h = {refMem[a + ((f3 == 3'd2) ? 0 : 1) % 512], refMem[a]};
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return {refMem[a + 3], refMem[a + 2], refMem[a + 1], refMem[a]};
        endcase
    endfunction

    // Issues one request, holding req_valid until accepted, and records the expected response.
    task automatic applyStimulus(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output int readyLowCycles);
        exp_t e;
        bit   acc;
        int   nb;
        acc = 1'b0;
        readyLowCycles = 0;
        while (!acc && readyLowCycles < 20) begin
            @(negedge clk);
            req_valid    = 1'b1;
            req_is_store = st;
            req_funct3   = f3;
            req_addr     = a;
            req_wdata    = wd;
            if (req_ready) begin
                e.err         = refIsError(st, f3, a);
                e.rdata       = 32'd0;
                e.acceptCycle = cycleCount;
                e.latency     = 1;
                e.writes      = 0;
                e.wAddr       = 32'd0;
                e.wData       = 32'd0;
                if (!e.err && !st) begin
                    e.rdata   = refLoad(f3, int'(a));
                    e.latency = 3;
                end else if (!e.err) begin
                    nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
                    for (int i = 0; i < nb; i++) refMem[int'(a) + i] = wd[8*i +: 8];
                    e.latency = (nb == 4) ? 3 : 5;
                    e.writes  = 1;
                    e.wAddr   = a & ~32'd3;
                    e.wData   = {refMem[e.wAddr + 3], refMem[e.wAddr + 2],
                                 refMem[e.wAddr + 1], refMem[e.wAddr]};
                end
                expQ.push_back(e);
                @(posedge clk);
                acc = 1'b1;
            end else begin
                readyLowCycles++;
            end
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no acceptance, expected req_ready within 20 cycles");
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", expQ.size());
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
        checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        checkOutput({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
        checkOutput({tag, "_resp_rdata"}, resp_rdata,          32'd0);
        checkOutput({tag, "_mem_addr"},   mem_addr,            32'd0);
        checkOutput({tag, "_mem_write"},  {28'd0, mem_write},  32'd0);
        checkOutput({tag, "_mem_wdata"},  mem_wdata,           32'd0);
    endtask

    // Monitor: pops one expectation per response and audits the writes seen since the previous one.
    int          wrCount = 0;
    logic [31:0] lastWAddr, lastWData;
    exp_t        me;

    always @(negedge clk) begin
        if (reset) begin
            expQ.delete();
            wrCount = 0;
        end else begin
            if (mem_write != 4'd0) begin
                wrCount++;
                lastWAddr = mem_addr;
                lastWData = mem_wdata;
                checkOutput("mem_write_value", {28'd0, mem_write}, 32'd1);
            end
            if (resp_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp: got resp_valid=1, expected no response");
                end else begin
                    me = expQ.pop_front();
                    checkOutput("resp_err",   {31'd0, resp_err}, {31'd0, me.err});
                    checkOutput("resp_rdata", resp_rdata, me.rdata);
                    checkOutput("latency",    cycleCount - me.acceptCycle, me.latency);
                    checkOutput("write_count", wrCount, me.writes);
                    if (me.writes > 0) begin
                        checkOutput("write_addr", lastWAddr, me.wAddr);
                        checkOutput("write_data", lastWData, me.wData);
                    end
                end
                wrCount = 0;
            end
        end
    end

    initial begin
        int         rl;
        logic [7:0] saved[4];
        logic [31:0] a;

        for (int i = 0; i < 128; i++) begin
            memWords[i] = 32'(i + 12);
            refMem[4*i]     = 8'(i + 12);
            refMem[4*i + 1] = 8'd0;
            refMem[4*i + 2] = 8'd0;
            refMem[4*i + 3] = 8'd0;
        end
        reset = 1'b1;
        req_valid = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;

        applyStimulus(1'b0, 3'd2, 32'h4, 32'd0, rl);
        applyStimulus(1'b1, 3'd0, 32'h9, 32'hFFFFFF80, rl);
        applyStimulus(1'b0, 3'd0, 32'h9, 32'd0, rl);
        applyStimulus(1'b0, 3'd4, 32'h9, 32'd0, rl);
        applyStimulus(1'b0, 3'd2, 32'h8, 32'd0, rl);
        applyStimulus(1'b1, 3'd1, 32'hE, 32'h1234ABCD, rl);
        applyStimulus(1'b0, 3'd1, 32'hE, 32'd0, rl);
        applyStimulus(1'b0, 3'd5, 32'hE, 32'd0, rl);
        applyStimulus(1'b0, 3'd1, 32'hC, 32'd0, rl);
        applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rl);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'd0, rl);
        checkOutput("b2b_ready_low_cycles", rl, 32'd2);
        applyStimulus(1'b0, 3'd2, 32'h6, 32'd0, rl);
        applyStimulus(1'b1, 3'd1, 32'h3, 32'h5555AAAA, rl);
        applyStimulus(1'b0, 3'd2, 32'h200, 32'd0, rl);
        applyStimulus(1'b0, 3'd3, 32'h20, 32'd0, rl);
        applyStimulus(1'b0, 3'd2, 32'h4, 32'd0, rl);
        waitDrain();

        // Reset during ST_MERGE of a byte store: the store must leave no trace.
        for (int i = 0; i < 4; i++) saved[i] = refMem[i];
        applyStimulus(1'b1, 3'd0, 32'h0, $urandom, rl);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) refMem[i] = saved[i];
        @(negedge clk);
        checkResetState("midop_reset");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 3'd2, 32'h0, 32'd0, rl);
        waitDrain();

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = 32'd512 + 32'($urandom_range(0, 600));
            end else begin
                a = 32'($urandom_range(0, 127)) * 4;
                if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(0, 3));
            end
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rl);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
        end
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
